// File: rtl/ray_pkg.sv
// Shared types and widths for the ray tracer datapath and its frame scheduler.
package ray_pkg;

  localparam int unsigned DX_W     = 11;
  localparam int unsigned DY_W     = 11;
  localparam int unsigned DZ_W     = 9;
  localparam int unsigned DIR_W    = DX_W + DY_W + DZ_W;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned ORIGIN_W = 28;

  typedef struct packed {
    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;
    logic [DZ_W-1:0] dz;
  } ray_dir_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite,
    StDone
  } sched_state_e;

  function automatic logic [DIR_W-1:0] pack_dir(input logic [DX_W-1:0] dx,
                                                input logic [DY_W-1:0] dy,
                                                input logic [DZ_W-1:0] dz);
    return {dx, dy, dz};
  endfunction

  function automatic ray_dir_t unpack_dir(input logic [DIR_W-1:0] dir);
    return ray_dir_t'(dir);
  endfunction

endpackage

// File: rtl/ray_frame_scheduler_if.sv
// Pixel write bus from the frame scheduler to the framebuffer writer.
interface ray_frame_scheduler_if #(
  parameter int unsigned ADDR_W = 19
);

  logic                         px_valid;
  logic                         px_ready;
  logic [ADDR_W-1:0]            px_addr;
  logic [ray_pkg::COLOR_W-1:0]  px_data;

  modport master (output px_valid, output px_addr, output px_data, input px_ready);
  modport slave  (input px_valid, input px_addr, input px_data, output px_ready);

endinterface

// File: rtl/ray_dir_gen.sv
// Combinational pixel (col,row) to ray direction mapping, centred on the screen midpoint.
module ray_dir_gen
  import ray_pkg::*;
#(
  parameter int unsigned   H_RES = 640,
  parameter int unsigned   V_RES = 480,
  parameter logic [8:0]    FOCAL = 9'd256,
  localparam int unsigned  COL_W = $clog2(H_RES),
  localparam int unsigned  ROW_W = $clog2(V_RES)
) (
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [DIR_W-1:0] dir
);

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;

  // Two's complement wrap at 11 bits is intended.
  always_comb begin
    dx  = DX_W'(col) - DX_W'(H_RES / 2);
    dy  = DY_W'(V_RES / 2) - DY_W'(row);
    dir = pack_dir(dx, dy, FOCAL);
  end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Frame sequencer: sweeps pixels in raster order, issues rays, writes colours out.
// Optional feature macro: RAY_SCHED_BG_COLOR_EN (background colour on tracer miss).
module ray_frame_scheduler
  import ray_pkg::*;
#(
  parameter int unsigned  H_RES     = 640,
  parameter int unsigned  V_RES     = 480,
  parameter int unsigned  ADDR_W    = 19,
  parameter int unsigned  TRACE_LAT = 4,
  parameter logic [8:0]   FOCAL     = 9'd256,
  parameter logic [11:0]  BG_COLOR  = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ORIGIN_W-1:0] cam_pos,
  output logic                busy,
  output logic                done,
  output logic [ORIGIN_W-1:0] tr_init,
  output logic [DIR_W-1:0]    tr_dir,
  input  logic [COLOR_W-1:0]  tr_dout,
  input  logic                tr_collision,
  ray_frame_scheduler_if.master px
);

  localparam int unsigned COL_W = $clog2(H_RES);
  localparam int unsigned ROW_W = $clog2(V_RES);
  localparam int unsigned CNT_W = 4;

  sched_state_e       state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]  pix_cnt;
  logic [DIR_W-1:0]   dir_next;
  logic [COLOR_W-1:0] cap_color;
  logic               last_col;
  logic               last_row;

  ray_dir_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .FOCAL (FOCAL)
  ) u_dir_gen (
    .col (col),
    .row (row),
    .dir (dir_next)
  );

`ifdef RAY_SCHED_BG_COLOR_EN
  assign cap_color = tr_collision ? tr_dout : BG_COLOR;
`else
  logic [COLOR_W:0] unused_bg;
  assign unused_bg = {tr_collision, BG_COLOR};
  assign cap_color = tr_dout;
`endif

  assign last_col = (col == COL_W'(H_RES - 1));
  assign last_row = (row == ROW_W'(V_RES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      col         <= '0;
      row         <= '0;
      wait_cnt    <= '0;
      pix_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tr_init     <= '0;
      tr_dir      <= '0;
      px.px_valid <= 1'b0;
      px.px_addr  <= '0;
      px.px_data  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            tr_init <= cam_pos;
            col     <= '0;
            row     <= '0;
            pix_cnt <= '0;
            busy    <= 1'b1;
            state   <= StIssue;
          end
        end
        StIssue: begin
          tr_dir   <= dir_next;
          wait_cnt <= CNT_W'(TRACE_LAT);
          state    <= StWait;
        end
        // Capture lands TRACE_LAT+1 edges after issue: count down, then one more edge.
        StWait: begin
          if (wait_cnt == '0) begin
            px.px_data  <= cap_color;
            px.px_addr  <= pix_cnt;
            px.px_valid <= 1'b1;
            state       <= StWrite;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        StWrite: begin
          if (px.px_ready) begin
            px.px_valid <= 1'b0;
            pix_cnt     <= pix_cnt + ADDR_W'(1);
            if (last_col && last_row) begin
              done  <= 1'b1;
              state <= StDone;
            end else if (last_col) begin
              col   <= '0;
              row   <= row + ROW_W'(1);
              state <= StIssue;
            end else begin
              col   <= col + COL_W'(1);
              state <= StIssue;
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
- Frame-level sequencer for the `ray_tracer` datapath.
- On `start`, sweeps every pixel in raster order and drives one ray direction per pixel into the tracer.
- Waits a fixed tracer latency, then captures `dout` and `collision_ret`.
- Delivers each pixel colour to the framebuffer writer through a valid/ready handshake.
- Sits between the top-level frame control and the `ray_tracer` instance; the scene bus is routed to the tracer directly, not through this block.

Parameters:
- H_RES, 640, pixels per row (2..1024)
- V_RES, 480, rows per frame (2..1024)
- ADDR_W, 19, pixel address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- TRACE_LAT, 4, cycles from `tr_dir` stable to `tr_dout`/`tr_collision` valid (1..15)
- FOCAL, 9'd256, constant z component of every ray
- BG_COLOR, 12'h000, background colour (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise
- cam_pos  in  28  camera origin; sampled on accepted `start`
- busy  out  1  high from accepted `start` until DONE is left
- done  out  1  one-cycle pulse after the last pixel write is accepted
- tr_init  out  28  tracer origin; held at the latched `cam_pos` for the whole frame
- tr_dir  out  31  {dx[10:0], dy[10:0], dz[8:0]}, dx/dy in two's complement
- tr_dout  in  12  tracer colour
- tr_collision  in  1  tracer hit flag
- px_valid  out  1  pixel write request
- px_ready  in  1  framebuffer accepts the write
- px_addr  out  ADDR_W  row*H_RES+col
- px_data  out  12  pixel colour

Behaviour:
- Reset (async, rst=1): state=IDLE; col=0; row=0; wait counter=0; busy=0; done=0; px_valid=0; px_addr=0; px_data=0; tr_dir=0; tr_init=0.
- Ray direction for pixel (col,row), all arithmetic at 11-bit signed, truncated:
  - dx = col - H_RES/2
  - dy = V_RES/2 - row
  - dz = FOCAL
- State machine:
  - IDLE: on start=1, latch cam_pos into tr_init, clear col/row, set busy=1, go to ISSUE.
  - ISSUE: drive tr_dir for the current pixel, load wait counter=TRACE_LAT, go to WAIT. tr_dir holds its value until the next ISSUE.
  - WAIT: decrement the counter. When the counter reaches 0, capture tr_dout into px_data, set px_addr=row*H_RES+col, set px_valid=1, go to WRITE. Issue-to-capture latency is exactly TRACE_LAT+1 cycles.
  - WRITE: hold px_valid/px_addr/px_data stable until px_ready=1. On the accepting edge:
    - drop px_valid;
    - if col=H_RES-1 and row=V_RES-1, go to DONE;
    - else if col=H_RES-1, set col=0, row+=1, go to ISSUE;
    - else col+=1, go to ISSUE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Handshake rules:
  - px_valid never drops without px_ready.
  - px_ready while px_valid=0 is ignored.
  - px_valid may be asserted in the same cycle px_ready is already high; the transfer completes on that edge.
- start while busy is ignored; no restart or queueing.
- px_addr is produced by an incremental counter, not a multiplier: +1 per accepted write, reset to 0 on frame start.
- Reset mid-frame returns to IDLE immediately; the partial frame is abandoned and no done pulse is issued.
- Back-to-back frames: start may be accepted in the cycle after done.

Optional Feature:
- Macro: RAY_SCHED_BG_COLOR_EN.
- Defined: if tr_collision=0 at the capture cycle, px_data=BG_COLOR; otherwise px_data=tr_dout.
- Undefined: px_data=tr_dout always, and tr_collision is ignored. The port remains present in both builds.

Decomposition:
- Shared package `ray_pkg`:
  - dir field widths (11/11/9) and the {dx,dy,dz} pack/unpack helper;
  - colour width 12;
  - origin width 28;
  - scheduler state encoding (IDLE, ISSUE, WAIT, WRITE, DONE).
- One natural sub-module, `ray_dir_gen`: combinational (col,row) -> tr_dir mapping, so that other samplers can reuse it. The FSM and counters stay in the top module.

Test Plan:
- H_RES=4, V_RES=2, TRACE_LAT=3, px_ready tied 1, tracer model returns dout=pixel index: expect 8 writes, px_addr 0..7, px_data matches, done pulse one cycle after the 8th write, each pixel 6 cycles apart.
- Pixel (0,0) with FOCAL=4: tr_dir = {11'h7FE, 11'd1, 9'd4}. Pixel (3,1): tr_dir = {11'd1, 11'd0, 9'd4}.
- Hold px_ready=0 for 10 cycles on pixel 2: px_valid, px_addr=2 and px_data stay stable; no tr_dir change until acceptance.
- Pulse start mid-frame: ignored; busy stays 1 and the address sequence is uninterrupted. Assert rst at pixel 5: all outputs return to reset values in the same cycle; no done pulse.
- With RAY_SCHED_BG_COLOR_EN and BG_COLOR=12'hABC, tracer drives collision=0 on odd pixels: odd px_data=12'hABC, even px_data=tr_dout. Without the macro, all pixels equal tr_dout.
